// File: rtl/adder_stream_acc_if.sv
// Valid/ready stream bundle for adder_stream_acc: operand beats in, frame results out.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface adder_stream_acc_if #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_carries;
    logic             out_sat;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carries,
        output out_sat
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carries,
        input  out_sat
    );
endinterface

// File: rtl/adder_stream_acc.sv
// Streaming frame accumulator: sums each in_last-delimited frame through one combinational
// adder and presents the modular sum plus a saturating carry count on a held output.

module adder #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module adder_stream_acc_chk #(
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic [CNT_W-1:0] cnt,
    input logic             sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    a_no_ready_while_holding: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> !in_ready);

    a_sat_only_at_max: assert property (@(posedge clk) disable iff (rst)
        sat |-> (cnt == CNT_MAX));
endmodule

module adder_stream_acc #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 4
) (
    input logic                clk,
    input logic                rst,
    adder_stream_acc_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ACC_ZERO = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             in_ready_s;
    logic             accept_s;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc_r),
        .b    (bus.in_data),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Ready is a pure decode of state and reset so out_ready never reaches it.
    assign in_ready_s = (state_r == ST_ACC) && !rst;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Frame FSM with accumulator, carry counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACC;
            acc_r       <= ACC_ZERO;
            cnt_r       <= CNT_ZERO;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        acc_r <= sum_s;
                        if (cout_s) begin
                            if (cnt_r != CNT_MAX) begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end else begin
                                sat_r <= 1'b1;
                            end
                        end
                        if (bus.in_last) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_ACC;
                        acc_r       <= ACC_ZERO;
                        cnt_r       <= CNT_ZERO;
                        sat_r       <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    acc_r       <= ACC_ZERO;
                    cnt_r       <= CNT_ZERO;
                    sat_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_sum     = acc_r;
    assign bus.out_carries = cnt_r;
    assign bus.out_sat     = sat_r;

    adder_stream_acc_chk #(.CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready_s),
        .out_valid (out_valid_r),
        .cnt       (cnt_r),
        .sat       (sat_r)
    );
endmodule

// File: doc/adder_stream_acc.md
# adder_stream_acc

Streaming frame accumulator wrapped around the team's parameterised `adder` (a, b, s, cout). It sits upstream of the adder as operand feeder and downstream of it as result/carry consumer. It accepts a valid/ready stream of WIDTH-bit operands, sums each frame (delimited by `in_last`) through a single `adder` instance, and presents the frame's modular sum plus a carry count on a registered valid/ready output.

## Interface

- `WIDTH`, 7: operand and sum width; passed unchanged to the `adder` instance.
- `CNT_W`, 4: width of the saturating carry counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  operand.
- `in_last`  in  1  marks the final beat of a frame; qualified by the accept.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  WIDTH  frame sum mod 2^WIDTH.
- `out_carries`  out  CNT_W  number of adder carry-outs in the frame, saturating at 2^CNT_W−1.
- `out_sat`  out  1  set if a carry occurred while `out_carries` was already at max.

## Operation

- Two states: ACC (accepting beats) and DONE (holding result).
- Datapath: one `adder #(WIDTH)` instance, a = acc register, b = `in_data`; s → next acc; cout → carry counter increment.
- Accept = `in_valid && in_ready`. `in_ready` = 1 only in ACC and only when `rst` is low.
- ACC, on accept:
  - acc ← s.
  - If cout = 1: if cnt < max, cnt ← cnt+1; else sat ← 1.
  - If `in_last` = 1: go to DONE.
- ACC, no accept: hold all state. `in_last` without `in_valid` is ignored.
- DONE: `out_valid` = 1; `out_sum` = acc, `out_carries` = cnt, `out_sat` = sat. All held stable until handshake. `in_valid` and `in_data` are ignored.
- DONE with `out_valid && out_ready`: acc, cnt and sat clear to 0; go to ACC.
- Arithmetic:
  - `out_sum` = (Σ in_data) mod 2^WIDTH.
  - Unsaturated `out_carries` = floor(Σ in_data / 2^WIDTH).
  - Each beat adds at most one carry.
- Single-beat frame (first beat has `in_last`) is legal: result = that operand, 0 carries.
- Reset (any state, including mid-frame or mid-hold):
  - state ← ACC; acc, cnt, sat ← 0; `out_valid` ← 0.
  - A partial frame is discarded with no output.
  - A pending result is dropped.

## Timing

- Reset values: `out_valid` 0, `out_sum` 0, `out_carries` 0, `out_sat` 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Throughput: one beat per cycle within a frame. `in_valid` may remain high continuously.
- Latency: `out_valid` rises in the cycle after the accept of the `in_last` beat.
- Inter-frame gap: minimum one cycle. `in_ready` is low for every cycle `out_valid` is high, and rises the cycle after the output handshake.
- Outputs are registered. `in_ready` is a decode of state and `rst` only, with no combinational path from `out_ready`.
- Upstream must hold `in_data` and `in_last` stable while `in_valid` is high and `in_ready` is low.
- The adder is purely combinational, with one adder delay from acc/`in_data` to the acc D-input. No additional pipelining.

## Test plan

- Reset:
  - Stimulus: hold `rst` 3 cycles with `in_valid` = 1 and `in_data` = 9.
  - Required: `in_ready` = 0 and `out_valid` = 0 throughout; no beat is absorbed.
  - Required: after release, a frame {4, last} yields `out_sum` = 4.
- Single beat:
  - Stimulus: {5, last}.
  - Required: next cycle `out_valid` = 1, `out_sum` = 5, `out_carries` = 0, `out_sat` = 0.
- Carries:
  - Stimulus: frame {100, 100, 100(last)}, back-to-back.
  - Required: `out_sum` = 44, `out_carries` = 2, `out_sat` = 0.
- Saturation (defaults):
  - Stimulus: 17 beats of 127, last on the 17th (Σ = 2159).
  - Required: `out_sum` = 111, `out_carries` = 15, `out_sat` = 1.
- Backpressure:
  - Stimulus: after frame {1, 2(last)}, hold `out_ready` = 0 for 5 cycles while driving `in_valid` = 1 with `in_data` = 50.
  - Required: `out_valid` and `out_sum` = 3 stay stable and `in_ready` = 0.
  - Required: after `out_ready` pulses, the next frame {50, last} yields 50, with 0 carries.
- Reset mid-frame:
  - Stimulus: accept 100, 100, then pulse `rst` for 1 cycle, then frame {3, last}.
  - Required: `out_sum` = 3, `out_carries` = 0; no output for the aborted frame.
